// File: rtl/axi_hdr_pkg.sv
// Shared definitions for the AXI-Stream header-insertion control blocks.
//   - hdr_state_e   : header arbiter FSM states
//   - keep_is_legal : accepts only low-aligned contiguous byte masks (incl. 0)
//   - DEF_*         : default widths used by the blocks that import this package
package axi_hdr_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_WD = 32;
  localparam int DEF_CNT_WD  = 16;
  // Widest keep mask the legality check can take; narrower masks are zero-extended.
  localparam int MAX_KEEP_WD = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_LAST = 2'd2
  } hdr_state_e;

  // A legal mask has the form 2^k-1 (k >= 0). Adding one to such a mask
  // carries through every set bit, so the AND with the original is zero.
  // Any hole or non-zero bit 0 gap leaves a surviving bit.
  function automatic logic keep_is_legal(input logic [MAX_KEEP_WD-1:0] keep);
    return (keep & (keep + MAX_KEEP_WD'(1))) == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index; search runs cyclically from here
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : encoded index of the granted request (0 when none)
//   any       : at least one request present
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_WD  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_WD-1:0]  ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_WD-1:0]  grant_idx,
  output logic               any
);

  int                pos;
  logic [IDX_WD-1:0] pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_WD'(pos);
      if (!any && req[pos_idx]) begin
        any              = 1'b1;
        grant[pos_idx]   = 1'b1;
        grant_idx        = pos_idx;
      end
    end
  end

endmodule

// File: rtl/axi_header_arbiter.sv
// Header-insert channel arbiter for the AXI-Stream header-insertion datapath.
// Grants one header per packet round-robin among NUM_REQ sources, holds it in
// a register, offers it to the datapath and locks the grant until end of packet.
//   clk, rst                        : clock, asynchronous active-high reset
//   req_valid/req_header/req_keep   : per-requester header offer (packed, i at [i*W +: W])
//   req_ready                       : one-hot, one-cycle accept strobe (IDLE only)
//   valid_insert/header_insert/keep_insert, ready_insert : header offer to datapath
//   pkt_done                        : datapath end of packet
//   grant_id                        : current/last granted requester
//   busy                            : high in OFFER or WAIT_LAST
//   err_keep                        : one-cycle pulse when an illegal keep is rejected
//   pkt_cnt                         : completed packets, saturating
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. req_ready is a strobe the arbiter raises only
// toward a requester whose req_valid is already high, so req_valid & req_ready
// is the transfer. valid_insert is held with stable header/keep until the edge
// on which ready_insert is also high.
module axi_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter  int NUM_REQ      = DEF_NUM_REQ,
  parameter  int DATA_WD      = DEF_DATA_WD,
  parameter  int DATA_BYTE_WD = DATA_WD / 8,
  parameter  int CNT_WD       = DEF_CNT_WD,
  localparam int IDX_WD       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]        req_header,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                header_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  input  logic                              ready_insert,
  input  logic                              pkt_done,
  output logic [IDX_WD-1:0]                 grant_id,
  output logic                              busy,
  output logic                              err_keep,
  output logic [CNT_WD-1:0]                 pkt_cnt
);

  hdr_state_e              state, state_nxt;
  logic [IDX_WD-1:0]       ptr;
  logic [DATA_WD-1:0]      hold_hdr;
  logic [DATA_BYTE_WD-1:0] hold_keep;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_WD-1:0]       arb_idx;
  logic                    arb_any;
  logic [DATA_WD-1:0]      win_hdr;
  logic [DATA_BYTE_WD-1:0] win_keep;
  logic                    win_legal;

  // FSM decisions consumed by the datapath registers.
  logic accept;    // winner has a legal keep: capture it and offer
  logic reject;    // winner has an illegal keep: drop it, pulse err_keep
  logic handoff;   // datapath took the header: clear the hold registers
  logic complete;  // packet finished: advance pointer, count it

  function automatic logic [IDX_WD-1:0] wrap_inc(input logic [IDX_WD-1:0] i);
    return (i == IDX_WD'(NUM_REQ - 1)) ? '0 : i + IDX_WD'(1);
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign win_hdr   = req_header[arb_idx*DATA_WD +: DATA_WD];
  assign win_keep  = req_keep[arb_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign win_legal = keep_is_legal(MAX_KEEP_WD'(win_keep));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath decisions
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    handoff   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          if (win_legal) begin
            accept    = 1'b1;
            state_nxt = OFFER;
          end else begin
            reject = 1'b1;
          end
        end
      end
      OFFER: begin
        if (ready_insert) begin
          handoff = 1'b1;
          if (pkt_done) begin
            // Single-beat packet: header accepted and packet ended together.
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_LAST;
          end
        end
      end
      WAIT_LAST: begin
        if (pkt_done) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      hold_hdr  <= '0;
      hold_keep <= '0;
      grant_id  <= '0;
      err_keep  <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      err_keep <= reject;
      if (accept) begin
        hold_hdr  <= win_hdr;
        hold_keep <= win_keep;
        grant_id  <= arb_idx;
      end
      // A rejected header never reaches the hold registers, so nothing stale
      // is visible on header_insert; only the pointer moves past the offender.
      if (reject) ptr <= wrap_inc(arb_idx);
      if (handoff) begin
        hold_hdr  <= '0;
        hold_keep <= '0;
      end
      if (complete) begin
        ptr <= wrap_inc(grant_id);
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_WD'(1);
      end
    end
  end

  // req_ready is the only combinational output; it is masked while reset is
  // held so every output reads zero during reset.
  assign req_ready     = (state == IDLE && !rst) ? arb_grant : '0;
  assign valid_insert  = (state == OFFER);
  assign busy          = (state != IDLE);
  assign header_insert = hold_hdr;
  assign keep_insert   = hold_keep;

endmodule

// File: doc/axi_header_arbiter.md
Name: axi_header_arbiter

Overview:
- Shares the single header-insert channel of the AXI-Stream header-insertion datapath among NUM_REQ header sources.
- Accepts one header per packet using round-robin arbitration, holds it in a register, and offers it on valid_insert/header_insert/keep_insert.
- Locks the grant until the datapath reports the end of the packet.
- Rejects headers whose keep is not a legal low-aligned contiguous mask.

Parameters:
NUM_REQ, 4, number of header requesters (2..8)
DATA_WD, 32, header/data width in bits
DATA_BYTE_WD, DATA_WD/8, keep width in bits
CNT_WD, 16, width of the completed-packet counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester header valid
req_header  input  NUM_REQ*DATA_WD  packed headers, requester i at [i*DATA_WD +: DATA_WD]
req_keep  input  NUM_REQ*DATA_BYTE_WD  packed keep masks, same packing
req_ready  output  NUM_REQ  one-hot accept strobe to the granted requester
valid_insert  output  1  header valid to datapath
header_insert  output  DATA_WD  held header
keep_insert  output  DATA_BYTE_WD  held keep
ready_insert  input  1  datapath accepts header
pkt_done  input  1  datapath end of packet (valid_out & ready_out & last_out)
grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester
busy  output  1  high in OFFER or WAIT_LAST
err_keep  output  1  one-cycle pulse when an illegal keep is rejected
pkt_cnt  output  CNT_WD  completed packets, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0. Reset asserted mid-packet aborts immediately. No header is replayed after reset.
- States: IDLE, OFFER, WAIT_LAST.
- IDLE:
  - If any req_valid is high, pick the first set bit at or after the pointer, searching cyclically (winner g).
  - In the same cycle: assert req_ready[g] for exactly 1 cycle and load header/keep into the hold registers.
  - If keep is legal: set grant_id to g on the next edge and move to OFFER.
  - If keep is illegal: pulse err_keep the next cycle, drop the header, set pointer to g+1 mod NUM_REQ, stay in IDLE.
- Legal keep values: the all-zero mask, or 2^k-1 for k = 1..DATA_BYTE_WD. For a 4-byte keep these are 0000, 0001, 0011, 0111, 1111. Every other value is illegal.
- OFFER:
  - valid_insert = 1, driven from registers (no combinational path from req_*).
  - header_insert and keep_insert stay stable until ready_insert is seen.
  - On ready_insert, move to WAIT_LAST.
  - If ready_insert and pkt_done are both high in the same cycle, go directly to IDLE with the completion actions below.
- WAIT_LAST:
  - valid_insert = 0. header_insert and keep_insert are cleared to 0.
  - On pkt_done: go to IDLE, set pointer to grant_id+1 mod NUM_REQ, increment pkt_cnt (saturates at all-ones).
- pkt_done in IDLE, or in OFFER without ready_insert, is ignored.
- Latency: req_valid to valid_insert is 1 cycle. pkt_done to the next req_ready is 1 cycle (IDLE is visited for at least 1 cycle between packets).
- req_ready never asserts outside IDLE, and never for more than one requester.
- grant_id holds its last value in IDLE.

Decomposition:
- Shared package axi_hdr_pkg:
  - state enum (IDLE, OFFER, WAIT_LAST)
  - keep-legality function
  - default widths
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs: request vector, pointer
  - outputs: one-hot grant and encoded index
  - purely combinational
  - to be reused by other stream schedulers

Test Plan:
- Reset, then req_valid=0001 with header 0xAABBCCDD and keep 0111 -> req_ready=0001 for 1 cycle; next cycle valid_insert=1 with the same header and keep; ready_insert=1 -> WAIT_LAST; pkt_done -> IDLE, pkt_cnt=1.
- All four requesters valid continuously, ready_insert=1, pkt_done 3 cycles after each grant -> grant order 0,1,2,3,0; no requester granted twice in a row.
- ready_insert held low for 10 cycles in OFFER -> header_insert and keep_insert stable; no req_ready pulses; a pkt_done pulse in this window is ignored.
- Requester 2 presents keep 0101 -> req_ready[2] pulses, err_keep pulses once, valid_insert stays 0, next grant goes to requester 3 or later.
- rst asserted asynchronously during WAIT_LAST -> all outputs 0 immediately; after release, requester 0 wins first.
- ready_insert and pkt_done in the same OFFER cycle -> returns to IDLE, pkt_cnt increments; force pkt_cnt to 0xFFFF, complete a packet -> stays 0xFFFF.
